// File: rtl/button_pulse_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_pulse_conditioner_if
// Description : Groups the five raw pushbuttons, their debounced levels, the
//               centre-button pulse, the speed tick and the cursor speed value
//               into one bundle. The slave modport is the conditioner side.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_pulse_conditioner_if;
    logic       btnL_raw;
    logic       btnR_raw;
    logic       btnU_raw;
    logic       btnD_raw;
    logic       btnC_raw;
    logic       btnL;
    logic       btnR;
    logic       btnU;
    logic       btnD;
    logic       btnC;
    logic       CPulse;
    logic       tick;
    logic [5:0] speedo;

    modport slave (
        input  btnL_raw, btnR_raw, btnU_raw, btnD_raw, btnC_raw,
        output btnL, btnR, btnU, btnD, btnC, CPulse, tick, speedo
    );

    modport master (
        output btnL_raw, btnR_raw, btnU_raw, btnD_raw, btnC_raw,
        input  btnL, btnR, btnU, btnD, btnC, CPulse, tick, speedo
    );
endinterface
`default_nettype wire

// File: rtl/button_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_pulse_conditioner
// Description : Synchronizes and debounces five pushbuttons, emits a one-clock
//               pulse on each centre-button press, generates a periodic speed
//               tick and (optionally) a cursor acceleration value that ramps
//               while any direction button is held.
//               Optional feature macro: CURSOR_ACCEL_EN (when undefined the
//               speed value is tied to 0 and its registers are not built).
// Revision    : 1.0 - initial release
// ============================================================================
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TICK_DIV        = 1000000
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    button_pulse_conditioner_if.slave   btn
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] c_DB_TERM   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] c_TICK_TERM = TW'(TICK_DIV - 1);

    // Bit order: 0=L, 1=R, 2=U, 3=D, 4=C
    logic [4:0] w_raw;
    logic [4:0] w_level;

    assign w_raw = {btn.btnC_raw, btn.btnD_raw, btn.btnU_raw, btn.btnR_raw, btn.btnL_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_btn
            logic          sync1_q, sync1_d;
            logic          sync2_q, sync2_d;
            logic          level_q, level_d;
            logic [CW-1:0] cnt_q,   cnt_d;

            // Two-stage synchronizer, then a counter that only flips the
            // level after the new value has been stable long enough.
            always_comb begin
                sync1_d = w_raw[gi];
                sync2_d = sync1_q;
                level_d = level_q;
                cnt_d   = '0;
                if (sync2_q != level_q) begin
                    if (cnt_q == c_DB_TERM) begin
                        level_d = ~level_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Synchronizer and debounce state registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign w_level[gi] = level_q;
        end
    endgenerate

    assign btn.btnL = w_level[0];
    assign btn.btnR = w_level[1];
    assign btn.btnU = w_level[2];
    assign btn.btnD = w_level[3];
    assign btn.btnC = w_level[4];

    logic          btnc_dly_q, btnc_dly_d;
    logic          cpulse_q,   cpulse_d;
    logic [TW-1:0] presc_q,    presc_d;
    logic          w_tick;

    assign w_tick = (presc_q == c_TICK_TERM);

    // Rising-edge detect on debounced btnC and free-running tick prescaler.
    always_comb begin
        btnc_dly_d = w_level[4];
        cpulse_d   = w_level[4] & ~btnc_dly_q;
        presc_d    = w_tick ? '0 : presc_q + 1'b1;
    end

    // Pulse and prescaler registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btnc_dly_q <= 1'b0;
            cpulse_q   <= 1'b0;
            presc_q    <= '0;
        end else begin
            btnc_dly_q <= btnc_dly_d;
            cpulse_q   <= cpulse_d;
            presc_q    <= presc_d;
        end
    end

    assign btn.CPulse = cpulse_q;
    assign btn.tick   = w_tick;

`ifdef CURSOR_ACCEL_EN
    logic       w_dir_held;
    logic [1:0] hold_cnt_q, hold_cnt_d;
    logic [5:0] speedo_q,   speedo_d;

    // Several directions at once still count as held; arbitration is downstream.
    assign w_dir_held = |w_level[3:0];

    // Ramp: three warm-up ticks, then +1 per tick up to 63; release clears at once.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        speedo_d   = speedo_q;
        if (!w_dir_held) begin
            hold_cnt_d = 2'd0;
            speedo_d   = 6'd0;
        end else if (w_tick) begin
            if (hold_cnt_q == 2'd3) begin
                if (speedo_q != 6'd63) begin
                    speedo_d = speedo_q + 6'd1;
                end
            end else begin
                hold_cnt_d = hold_cnt_q + 2'd1;
            end
        end
    end

    // Acceleration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_q <= 2'd0;
            speedo_q   <= 6'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            speedo_q   <= speedo_d;
        end
    end

    assign btn.speedo = speedo_q;
`else
    assign btn.speedo = 6'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_pulse_conditioner
// Description : Directed self-checking bench for button_pulse_conditioner with
//               DEBOUNCE_CYCLES=4 and TICK_DIV=8. Acceleration scenarios run
//               when CURSOR_ACCEL_EN is defined; otherwise speedo must stay 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_pulse_conditioner;

    localparam int DB = 4;
    localparam int TD = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    button_pulse_conditioner_if bus ();

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .TICK_DIV        (TD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected speed after the n-th tick seen with a direction held.
    function automatic int exp_speed(input int n);
        if (n <= 3) return 0;
        if (n - 3 > 63) return 63;
        return n - 3;
    endfunction

    // Step for a number of cycles; after every tick taken while a direction is
    // held, compare speedo against the hand-derived ramp. Optionally stop once
    // speedo reaches stop_at.
    task automatic track(input string tag, input int cycles, input int stop_at, output int n);
        logic dir;
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            dir = bus.btnL | bus.btnR | bus.btnU | bus.btnD;
            if (bus.tick && dir) begin
                n++;
                step();
                chk(tag, int'(bus.speedo), exp_speed(n));
                if (int'(bus.speedo) == stop_at) break;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        int n;
        int found;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.btnL_raw = 1'b0;
        bus.btnR_raw = 1'b0;
        bus.btnU_raw = 1'b0;
        bus.btnD_raw = 1'b0;
        bus.btnC_raw = 1'b0;

        // Reset state
        step(); step();
        chk("rst_btnC",   int'(bus.btnC),   0);
        chk("rst_cpulse", int'(bus.CPulse), 0);
        chk("rst_tick",   int'(bus.tick),   0);
        chk("rst_speedo", int'(bus.speedo), 0);
        rst_n = 1'b1;

        // Tick: first strobe 7 edges after release, then every 8 cycles
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("tick_phase", int'(bus.tick), (k == 7 || k == 15) ? 1 : 0);
        end

        // Glitch of 3 cycles is rejected
        bus.btnC_raw = 1'b1;
        step(); step(); step();
        bus.btnC_raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("glitch_btnC",   int'(bus.btnC),   0);
            chk("glitch_cpulse", int'(bus.CPulse), 0);
        end

        // Press and hold: level at edge 6, single pulse at edge 7
        bus.btnC_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("press_btnC",   int'(bus.btnC),   (k >= 6) ? 1 : 0);
            chk("press_cpulse", int'(bus.CPulse), (k == 7) ? 1 : 0);
        end
        // Release: level drops at edge 6, never a pulse
        bus.btnC_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("rel_btnC",   int'(bus.btnC),   (k >= 6) ? 0 : 1);
            chk("rel_cpulse", int'(bus.CPulse), 0);
        end

        // Reset mid-debounce abandons progress; held button re-debounces
        bus.btnC_raw = 1'b1;
        step(); step(); step(); step();
        rst_n = 1'b0;
        step();
        chk("midrst_btnC",   int'(bus.btnC),   0);
        chk("midrst_cpulse", int'(bus.CPulse), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("rerst_cpulse", int'(bus.CPulse), (k == 7) ? 1 : 0);
        end
        bus.btnC_raw = 1'b0;
        for (int k = 0; k < 8; k++) step();

`ifdef CURSOR_ACCEL_EN
        // btnR held 100 cycles: 3 warm-up ticks, then +1 per tick
        bus.btnR_raw = 1'b1;
        track("ramp_R", 100, -1, n);
        chk("ramp_R_ticks", (n >= 10) ? 1 : 0, 1);
        bus.btnR_raw = 1'b0;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            if (!bus.btnR) begin found = 1; break; end
            step();
        end
        chk("rel_R_seen", found, 1);
        step();
        chk("rel_R_speedo", int'(bus.speedo), 0);

        // btnU held 600 cycles: saturates at 63
        bus.btnU_raw = 1'b1;
        track("ramp_U", 600, -1, n);
        chk("sat_U", int'(bus.speedo), 63);
        bus.btnU_raw = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("rel_U_speedo", int'(bus.speedo), 0);

        // btnL to speedo=5, one-cycle reset, ramp restarts from scratch
        bus.btnL_raw = 1'b1;
        track("ramp_L", 200, 5, n);
        chk("L_reached5", int'(bus.speedo), 5);
        rst_n = 1'b0;
        step();
        chk("L_rst_speedo", int'(bus.speedo), 0);
        chk("L_rst_btnL",   int'(bus.btnL),   0);
        rst_n = 1'b1;
        track("ramp_L2", 80, -1, n);
        chk("L2_speedo", int'(bus.speedo), exp_speed(n));
        bus.btnL_raw = 1'b0;
        for (int k = 0; k < 10; k++) step();
`else
        // Acceleration absent: speedo stays 0 while a direction is held,
        // and the tick keeps its 8-cycle period
        bus.btnD_raw = 1'b1;
        found = 0;
        for (int k = 0; k < 16; k++) begin
            if (bus.tick) begin found = 1; break; end
            step();
        end
        chk("noacc_tick_seen", found, 1);
        for (int k = 1; k <= 200; k++) begin
            step();
            chk("noacc_tick",   int'(bus.tick),   (k % 8 == 0) ? 1 : 0);
            chk("noacc_speedo", int'(bus.speedo), 0);
        end
        chk("noacc_btnD", int'(bus.btnD), 1);
        bus.btnD_raw = 1'b0;
        for (int k = 0; k < 10; k++) step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
